serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB-first through
// a 1-bit full-adder cell and reports sum, carry-out, signed overflow and group propagate.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             p_all
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_ss;
    logic             r_c;
    logic             r_pa;
    logic [CW-1:0]    r_cnt;

    logic             w_ai;
    logic             w_bi;
    logic             w_p;
    logic             w_si;
    logic             w_co;
    logic             w_last;

    // 1-bit full-adder cell; generate output is not needed without lookahead
    assign w_ai   = r_sa[0];
    assign w_bi   = r_sb[0];
    assign w_p    = w_ai ^ w_bi;
    assign w_si   = w_p ^ r_c;
    assign w_co   = (w_ai & w_bi) | (w_p & r_c);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status flags registered from the next state so they track the state register exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (w_state_nxt != S_IDLE);
            done <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_ss  <= '0;
            r_c   <= 1'b0;
            r_pa  <= 1'b0;
            r_cnt <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            p_all <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_c   <= cin;
                        r_pa  <= 1'b1;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_ss  <= {w_si, r_ss[WIDTH-1:1]};
                    r_c   <= w_co;
                    r_pa  <= r_pa & w_p;
                    r_cnt <= r_cnt + CW'(1);
                    // On the MSB step r_c is the carry into the MSB
                    if (w_last) begin
                        sum   <= {w_si, r_ss[WIDTH-1:1]};
                        cout  <= w_co;
                        ovf   <= r_c ^ w_co;
                        p_all <= r_pa & w_p;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
